// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register countdown to forwardability; stalls IF/ID and bubbles EX on RAW/WAW/mul-busy.
// Latency: stall outputs are combinational from current state (0 cycles); state updates on the next edge.
// Backpressure: a stalled ID instruction is re-evaluated every cycle; HAZARD_STATS_EN enables the stall counter.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 3,
  parameter int ALU_LAT    = 1,
  parameter int LOAD_LAT   = 2,
  parameter int MUL_LAT    = 4,
  parameter int MUL_II     = 4,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Issue_ID,
  input  logic [1:0]            OpClass_ID,
  input  logic [REG_ADDR_W-1:0] WriteReg_ID,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  UsesRs_ID,
  input  logic                  UsesRt_ID,
  input  logic                  Branch_ID,
  output logic                  Stall_IF,
  output logic                  Stall_ID,
  output logic                  Flush_EX,
  output logic [STAT_W-1:0]     StallCount
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_LOAD = 2'b01,
    OP_MUL  = 2'b10,
    OP_NONE = 2'b11
  } op_class_e;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [CNT_W-1:0] mul_busy_q;
  logic [CNT_W-1:0] mul_busy_d;
  logic [CNT_W-1:0] lat;
  logic             writes_reg;
  logic             is_mul;
  logic             raw_s;
  logic             raw_t;
  logic             waw;
  logic             struct_haz;
  logic             stall;
  logic             issue;

  always_comb begin
    lat = '0;
    case (op_class_e'(OpClass_ID))
      OP_ALU:  lat = CNT_W'(ALU_LAT);
      OP_LOAD: lat = CNT_W'(LOAD_LAT);
      OP_MUL:  lat = CNT_W'(MUL_LAT);
      default: lat = '0;
    endcase
  end

  assign writes_reg = (OpClass_ID != OP_NONE) && (WriteReg_ID != '0);
  assign is_mul     = (OpClass_ID == OP_MUL);

  // A count of 1 means the result reaches EX forwarding in time; branches compare in ID and need 0.
  assign raw_s = UsesRs_ID && (Rs_ID != '0) &&
                 (Branch_ID ? (cnt_q[Rs_ID] != '0) : (cnt_q[Rs_ID] > CNT_W'(1)));
  assign raw_t = UsesRt_ID && (Rt_ID != '0) &&
                 (Branch_ID ? (cnt_q[Rt_ID] != '0) : (cnt_q[Rt_ID] > CNT_W'(1)));
  assign waw        = writes_reg && (cnt_q[WriteReg_ID] > lat);
  assign struct_haz = is_mul && (mul_busy_q != '0);

  assign stall    = Issue_ID && (raw_s || raw_t || waw || struct_haz);
  assign issue    = Issue_ID && !stall;
  assign Stall_IF = stall;
  assign Stall_ID = stall;
  assign Flush_EX = stall;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
    end
    if (issue && writes_reg) begin
      cnt_d[WriteReg_ID] = lat;
    end
    cnt_d[0] = '0;
    mul_busy_d = (mul_busy_q != '0) ? mul_busy_q - CNT_W'(1) : '0;
    if (issue && is_mul) begin
      mul_busy_d = CNT_W'(MUL_II - 1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      mul_busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mul_busy_q <= mul_busy_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_q;
  logic [STAT_W-1:0] stat_d;

  assign stat_d = (stall && (stat_q != '1)) ? stat_q + STAT_W'(1) : stat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign StallCount = stat_q;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: timestamp-based reference model, directed pipeline scenarios, then random traffic.
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 3;
  localparam int ALU_LAT    = 1;
  localparam int LOAD_LAT   = 2;
  localparam int MUL_LAT    = 4;
  localparam int MUL_II     = 4;
  localparam int STAT_W     = 16;

  localparam logic [1:0] C_ALU  = 2'b00;
  localparam logic [1:0] C_LOAD = 2'b01;
  localparam logic [1:0] C_MUL  = 2'b10;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  Issue_ID;
  logic [1:0]            OpClass_ID;
  logic [REG_ADDR_W-1:0] WriteReg_ID;
  logic [REG_ADDR_W-1:0] Rs_ID;
  logic [REG_ADDR_W-1:0] Rt_ID;
  logic                  UsesRs_ID;
  logic                  UsesRt_ID;
  logic                  Branch_ID;
  logic                  Stall_IF;
  logic                  Stall_ID;
  logic                  Flush_EX;
  logic [STAT_W-1:0]     StallCount;

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
    .MUL_LAT(MUL_LAT), .MUL_II(MUL_II), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset), .Issue_ID(Issue_ID), .OpClass_ID(OpClass_ID),
    .WriteReg_ID(WriteReg_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_ID(Branch_ID),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Flush_EX(Flush_EX), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;

  // Reference model: absolute cycle at which each result / the multiplier becomes free.
  longint cyc = 0;
  longint ready_at [2**REG_ADDR_W];
  longint mul_free_at = 0;
  longint exp_cnt = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint lat_of(input logic [1:0] cls);
    case (cls)
      C_ALU:   return ALU_LAT;
      C_LOAD:  return LOAD_LAT;
      C_MUL:   return MUL_LAT;
      default: return 0;
    endcase
  endfunction

  function automatic longint pending(input int r);
    if (r == 0 || ready_at[r] <= cyc) return 0;
    return ready_at[r] - cyc;
  endfunction

  function automatic bit model_stall(input bit iss, input logic [1:0] cls, input int wr,
                                     input int rs, input int rt, input bit urs, input bit urt,
                                     input bit br);
    longint need;
    bit     h;
    need = br ? 0 : 1;
    h = 1'b0;
    if (urs && pending(rs) > need) h = 1'b1;
    if (urt && pending(rt) > need) h = 1'b1;
    if (cls != 2'b11 && pending(wr) > lat_of(cls)) h = 1'b1;
    if (cls == C_MUL && cyc < mul_free_at) h = 1'b1;
    return iss && h;
  endfunction

  task automatic model_reset();
    foreach (ready_at[i]) ready_at[i] = 0;
    mul_free_at = 0;
    exp_cnt = 0;
  endtask

  task automatic step(input bit iss, input logic [1:0] cls, input int wr, input int rs,
                      input int rt, input bit urs, input bit urt, input bit br, output bit stalled);
    bit exp;
    Issue_ID    = iss;
    OpClass_ID  = cls;
    WriteReg_ID = REG_ADDR_W'(wr);
    Rs_ID       = REG_ADDR_W'(rs);
    Rt_ID       = REG_ADDR_W'(rt);
    UsesRs_ID   = urs;
    UsesRt_ID   = urt;
    Branch_ID   = br;
    @(negedge clk);
    exp = model_stall(iss, cls, wr, rs, rt, urs, urt, br);
    check_val("Stall_ID", longint'(Stall_ID), longint'(exp));
    check_val("Stall_IF", longint'(Stall_IF), longint'(exp));
    check_val("Flush_EX", longint'(Flush_EX), longint'(exp));
    check_val("StallCount", longint'(StallCount), exp_cnt);
    stalled = Stall_ID;
    @(posedge clk);
`ifdef HAZARD_STATS_EN
    if (exp && exp_cnt < (longint'(1) << STAT_W) - 1) exp_cnt++;
`endif
    if (iss && !exp) begin
      if (cls != 2'b11 && wr != 0) ready_at[wr] = cyc + lat_of(cls) + 1;
      if (cls == C_MUL) mul_free_at = cyc + MUL_II;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit s;
    for (int k = 0; k < n; k++) step(1'b0, 2'b11, 0, 0, 0, 1'b0, 1'b0, 1'b0, s);
  endtask

  // Holds an instruction in ID until it issues; returns stall cycles, or -1 if it never issues.
  task automatic run_until_issue(input logic [1:0] cls, input int wr, input int rs, input int rt,
                                 input bit urs, input bit urt, input bit br, output int nst);
    bit s;
    bit done;
    nst  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, cls, wr, rs, rt, urs, urt, br, s);
      if (s) nst++;
      else done = 1'b1;
    end
    if (!done) nst = -1;
  endtask

  initial begin
    bit  s;
    int  nst;
    longint sc0;

    model_reset();
    reset       = 1'b0;
    Issue_ID    = 1'b1;
    OpClass_ID  = C_MUL;
    WriteReg_ID = 5'd3;
    Rs_ID       = 5'd3;
    Rt_ID       = 5'd4;
    UsesRs_ID   = 1'b1;
    UsesRt_ID   = 1'b1;
    Branch_ID   = 1'b1;
    #2;
    check_val("rst_Stall_ID", longint'(Stall_ID), 0);
    check_val("rst_StallCount", longint'(StallCount), 0);
    @(posedge clk);
    @(posedge clk);
    cyc = cyc + 2;
    #1 reset = 1'b1;
    idle(2);

    // 1: ALU producer then ALU consumer, then branch consumer
    step(1'b1, C_ALU, 8, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(C_ALU, 9, 8, 0, 1'b1, 1'b0, 1'b0, nst);
    check_val("alu_to_alu_stalls", nst, 0);
    idle(6);
    step(1'b1, C_ALU, 8, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(2'b11, 0, 8, 0, 1'b1, 1'b0, 1'b1, nst);
    check_val("alu_to_branch_stalls", nst, 1);
    idle(6);

    // 2: load-use
    step(1'b1, C_LOAD, 9, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(C_ALU, 10, 0, 9, 1'b0, 1'b1, 1'b0, nst);
    check_val("load_use_stalls", nst, 1);
    idle(6);

    // 3: mul-use
    step(1'b1, C_MUL, 10, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(C_ALU, 11, 10, 0, 1'b1, 1'b0, 1'b0, nst);
    check_val("mul_use_stalls", nst, 3);
    idle(6);

    // 4: back-to-back independent muls
    sc0 = longint'(StallCount);
    step(1'b1, C_MUL, 10, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(C_MUL, 12, 1, 2, 1'b1, 1'b1, 1'b0, nst);
    check_val("mul_struct_stalls", nst, 3);
`ifdef HAZARD_STATS_EN
    check_val("mul_struct_count", longint'(StallCount) - sc0, 3);
`else
    check_val("stat_tied_zero", longint'(StallCount), 0);
`endif
    idle(6);

    // 5: WAW, load after mul to same register
    step(1'b1, C_MUL, 10, 0, 0, 1'b0, 1'b0, 1'b0, s);
    run_until_issue(C_LOAD, 10, 0, 0, 1'b0, 1'b0, 1'b0, nst);
    check_val("waw_stalls", nst, 2);
    idle(6);

    // 6: reset while a dependent instruction is stalled
    step(1'b1, C_MUL, 10, 0, 0, 1'b0, 1'b0, 1'b0, s);
    step(1'b1, C_ALU, 11, 10, 0, 1'b1, 1'b0, 1'b0, s);
    #2;
    check_val("pre_reset_stall", longint'(Stall_ID), 1);
    reset = 1'b0;
    #1;
    check_val("async_rst_Stall_ID", longint'(Stall_ID), 0);
    check_val("async_rst_Stall_IF", longint'(Stall_IF), 0);
    check_val("async_rst_Flush_EX", longint'(Flush_EX), 0);
    check_val("async_rst_StallCount", longint'(StallCount), 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 reset = 1'b1;
    run_until_issue(C_ALU, 11, 10, 0, 1'b1, 1'b0, 1'b0, nst);
    check_val("post_reset_stalls", nst, 0);

    // Random traffic over a small register window to provoke frequent hazards
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
